// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate-generation stage: format selects, the
// not-found immediate, and the buffered entry layout sized for the widest build.
package imm_pkg;

  localparam int XLEN_MAX  = 64;
  localparam int TAG_W_MAX = 64;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_RSV = 3'b111
  } imm_sel_e;

  localparam logic [XLEN_MAX-1:0] IMM_NF = '0;

  // Narrower builds simply leave the upper imm/tag bits at zero.
  typedef struct packed {
    logic [XLEN_MAX-1:0]  imm;
    logic [TAG_W_MAX-1:0] tag;
    logic                 illegal;
  } imm_entry_t;

endpackage

// File: rtl/imm_gen_stage_extract.sv
// Combinational immediate extraction and XLEN extension for one instruction.
// Zero latency; no flow control of its own.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  imm_sel_e    sel_e;
  logic [31:0] imm32;
  logic        sext;
  logic [5:0]  shamt;
  logic        unused_opcode;

  assign sel_e         = imm_sel_e'(sel);
  assign unused_opcode = ^instr[6:0];
  // RV64 shifts take a 6-bit amount; RV32 only ever sees bit 25 as zero.
  assign shamt         = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

  always_comb begin
    imm32   = '0;
    sext    = 1'b1;
    illegal = 1'b0;
    case (sel_e)
      IMM_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:  imm32 = {instr[31:12], 12'b0};
      IMM_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z: begin
        imm32 = {27'b0, instr[19:15]};
        sext  = 1'b0;
      end
      IMM_SH: begin
        imm32 = {26'b0, shamt};
        sext  = 1'b0;
      end
      default: begin
        imm32   = IMM_NF[31:0];
        sext    = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate stage with main+skid buffer; results one cycle after accept.
// in_ready = !skid_full, so upstream stalls only after two results back up.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [2:0]           in_sel,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_illegal,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;
  imm_entry_t      new_ent;
  imm_entry_t      main_q;
  imm_entry_t      skid_q;
  logic            main_vld;
  logic            skid_vld;
  logic            in_fire;
  logic            out_fire;
  logic            unused_main;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (in_instr),
    .sel     (in_sel),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );

  assign in_ready = !skid_vld;
  // A flush outranks anything offered in the same cycle.
  assign in_fire  = in_valid && in_ready && !flush;
  assign out_fire = main_vld && out_ready;

  always_comb begin
    new_ent                  = '0;
    new_ent.imm[XLEN-1:0]    = ext_imm;
    new_ent.tag[TAG_W-1:0]   = in_tag;
    new_ent.illegal          = ext_illegal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || out_fire) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (in_fire) begin
        main_q   <= new_ent;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q   <= new_ent;
      skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (in_fire && ext_illegal && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  assign out_valid   = main_vld;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_tag     = main_q.tag[TAG_W-1:0];
  assign out_illegal = main_q.illegal;
  assign unused_main = ^main_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an RV32/2-bit-counter build and an RV64/16-bit-tag
// build share one stimulus stream and are checked against a queue model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_sel = '0;
  logic [31:0] in_tag = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm, a_out_tag;
  logic [1:0]  a_err_cnt;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [15:0] b_out_tag;
  logic [7:0]  b_err_cnt;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(32), .ERR_CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_imm(a_out_imm), .out_tag(a_out_tag),
    .out_illegal(a_out_illegal), .err_cnt(a_err_cnt)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(16), .ERR_CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag[15:0]), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_imm(b_out_imm), .out_tag(b_out_tag),
    .out_illegal(b_out_illegal), .err_cnt(b_err_cnt)
  );

  typedef struct packed {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   cnt_a = 0;
  int   cnt_b = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Field values rebuilt with shifts/masks and two's-complement adjustment.
  function automatic longint ref_imm(input logic [31:0] instr, input logic [2:0] sel, input bit x64);
    longint u, v;
    u = longint'({32'b0, instr});
    case (sel)
      3'd0: begin v = (u >> 20) & 'hFFF; if (v >= 2048) v -= 4096; end
      3'd1: begin v = (((u >> 25) & 'h7F) << 5) | ((u >> 7) & 'h1F); if (v >= 2048) v -= 4096; end
      3'd2: begin
        v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin v = u & 64'hFFFFF000; if (v >= 64'h80000000) v -= 64'h100000000; end
      3'd4: begin
        v = (((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      3'd5: v = (u >> 15) & 31;
      3'd6: v = x64 ? ((u >> 20) & 63) : ((u >> 20) & 31);
      default: v = 0;
    endcase
    return v;
  endfunction

  // One clock: drive at negedge, advance the model at posedge, return at next negedge.
  task automatic drive(input bit v, input logic [31:0] instr, input logic [2:0] sel,
                       input logic [31:0] tag, input bit ordy, input bit fl, output bit acc);
    bit     pop;
    exp_t   e;
    longint va, vb;
    in_valid = v; in_instr = instr; in_sel = sel; in_tag = tag; out_ready = ordy; flush = fl;
    acc = v && (q.size() < 2) && !fl;
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        va = ref_imm(instr, sel, 1'b0);
        vb = ref_imm(instr, sel, 1'b1);
        e.imm32 = va[31:0];
        e.imm64 = vb;
        e.tag   = tag;
        e.ill   = (sel == 3'd7);
        q.push_back(e);
        if (sel == 3'd7) begin
          if (cnt_a < 3)   cnt_a++;
          if (cnt_b < 255) cnt_b++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete(); cnt_a = 0; cnt_b = 0;
  endtask

  task automatic test_reset();
    bit acc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({a_out_valid, b_out_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b expected 00", {a_out_valid, b_out_valid}); end
    n_checks++; if (a_out_imm !== 32'h0 || b_out_imm !== 64'h0) begin n_fail++; $display("FAIL reset_imm: got %h/%h expected 0", a_out_imm, b_out_imm); end
    n_checks++; if (a_out_tag !== 32'h0 || b_out_tag !== 16'h0) begin n_fail++; $display("FAIL reset_tag: got %h/%h expected 0", a_out_tag, b_out_tag); end
    n_checks++; if ({a_out_illegal, b_out_illegal} !== 2'b00) begin n_fail++; $display("FAIL reset_illegal: got %b expected 00", {a_out_illegal, b_out_illegal}); end
    n_checks++; if (a_err_cnt !== 2'd0 || b_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d/%0d expected 0", a_err_cnt, b_err_cnt); end
    n_checks++; if ({a_in_ready, b_in_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 11", {a_in_ready, b_in_ready}); end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
    n_checks++; if ({a_in_ready, b_in_ready, a_out_valid} !== 3'b110) begin n_fail++; $display("FAIL reset_idle: got %b expected 110", {a_in_ready, b_in_ready, a_out_valid}); end
  endtask

  task automatic test_formats();
    logic [31:0] f_instr [9] = '{32'hFFF00093, 32'h00A12423, 32'hFE000FE3, 32'h123450B7, 32'h800000B7,
                                 32'hFF9FF06F, 32'h340A1073, 32'h03F00013, 32'hFFFFFFFF};
    logic [2:0]  f_sel   [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] f_e32   [9] = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFE, 32'h12345000, 32'h80000000,
                                 32'hFFFFFFF8, 32'h14, 32'h1F, 32'h0};
    logic [63:0] f_e64   [9] = '{64'hFFFFFFFFFFFFFFFF, 64'h8, 64'hFFFFFFFFFFFFFFFE, 64'h12345000,
                                 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFF8, 64'h14, 64'h3F, 64'h0};
    bit acc;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, f_instr[i], f_sel[i], 32'hA000_0000 + i, 1'b1, 1'b0, acc);
      n_checks++; if ({a_out_valid, b_out_valid, a_in_ready, b_in_ready} !== 4'b1111) begin n_fail++; $display("FAIL fmt%0d_handshake: got %b expected 1111", i, {a_out_valid, b_out_valid, a_in_ready, b_in_ready}); end
      n_checks++; if (a_out_imm !== f_e32[i]) begin n_fail++; $display("FAIL fmt%0d_imm32: got %h expected %h", i, a_out_imm, f_e32[i]); end
      n_checks++; if (b_out_imm !== f_e64[i]) begin n_fail++; $display("FAIL fmt%0d_imm64: got %h expected %h", i, b_out_imm, f_e64[i]); end
      n_checks++; if ({a_out_illegal, b_out_illegal} !== {2{f_sel[i] == 3'd7}}) begin n_fail++; $display("FAIL fmt%0d_illegal: got %b expected %b", i, {a_out_illegal, b_out_illegal}, {2{f_sel[i] == 3'd7}}); end
      n_checks++; if (a_out_tag !== 32'hA000_0000 + i || b_out_tag !== 16'(i)) begin n_fail++; $display("FAIL fmt%0d_tag: got %h/%h expected %h", i, a_out_tag, b_out_tag, 32'hA000_0000 + i); end
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL fmt_drain: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_backpressure();
    bit          st_ordy [6] = '{0, 0, 0, 1, 1, 1};
    bit          st_vld  [6] = '{1, 1, 1, 1, 1, 0};
    bit          st_rdy  [6] = '{1, 1, 0, 0, 1, 1};
    int          st_out  [6] = '{0, 0, 0, 1, 2, -1};
    logic [31:0] x_instr [3];
    logic [2:0]  x_sel   [3];
    int          k = 0;
    bit          acc;
    for (int i = 0; i < 3; i++) begin
      x_instr[i] = $urandom;
      x_sel[i]   = 3'($urandom_range(0, 6));
    end
    for (int s = 0; s < 6; s++) begin
      n_checks++; if ({a_in_ready, b_in_ready} !== {2{st_rdy[s]}}) begin n_fail++; $display("FAIL bp%0d_in_ready: got %b expected %b", s, {a_in_ready, b_in_ready}, {2{st_rdy[s]}}); end
      drive(st_vld[s] && k < 3, x_instr[k % 3], x_sel[k % 3], 32'hB0 + k, st_ordy[s], 1'b0, acc);
      if (acc) k++;
      n_checks++; if (a_out_valid !== (st_out[s] >= 0)) begin n_fail++; $display("FAIL bp%0d_valid: got %b expected %b", s, a_out_valid, st_out[s] >= 0); end
      if (st_out[s] >= 0) begin
        n_checks++; if (a_out_tag !== 32'hB0 + st_out[s]) begin n_fail++; $display("FAIL bp%0d_order: got %h expected %h", s, a_out_tag, 32'hB0 + st_out[s]); end
        n_checks++; if (a_out_imm !== q[0].imm32 || b_out_imm !== q[0].imm64) begin n_fail++; $display("FAIL bp%0d_imm: got %h/%h expected %h/%h", s, a_out_imm, b_out_imm, q[0].imm32, q[0].imm64); end
      end
    end
  endtask

  task automatic test_illegal_sat();
    int exp_a [5] = '{1, 2, 3, 3, 3};
    bit acc;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom, 3'd7, 32'hC0 + i, 1'b1, 1'b0, acc);
      n_checks++; if (a_err_cnt !== 2'(exp_a[i]) || b_err_cnt !== 8'(i + 1)) begin n_fail++; $display("FAIL sat%0d_err_cnt: got %0d/%0d expected %0d/%0d", i, a_err_cnt, b_err_cnt, exp_a[i], i + 1); end
      n_checks++; if (a_out_imm !== 32'h0 || b_out_imm !== 64'h0 || {a_out_illegal, b_out_illegal} !== 2'b11) begin n_fail++; $display("FAIL sat%0d_result: got %h/%h ill=%b expected 0 ill=11", i, a_out_imm, b_out_imm, {a_out_illegal, b_out_illegal}); end
    end
  endtask

  task automatic test_flush();
    bit acc;
    drive(1'b1, 32'h00100093, 3'd0, 32'hD0, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h00200093, 3'd0, 32'hD1, 1'b0, 1'b0, acc);
    n_checks++; if ({a_in_ready, a_out_valid} !== 2'b01) begin n_fail++; $display("FAIL flush_fill: got %b expected 01", {a_in_ready, a_out_valid}); end
    drive(1'b1, 32'hFFFFFFFF, 3'd7, 32'hDF, 1'b0, 1'b1, acc);
    n_checks++; if ({a_out_valid, b_out_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_valid: got %b expected 00", {a_out_valid, b_out_valid}); end
    n_checks++; if ({a_in_ready, b_in_ready} !== 2'b11) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 11", {a_in_ready, b_in_ready}); end
    n_checks++; if (a_err_cnt !== 2'(cnt_a) || b_err_cnt !== 8'(cnt_b)) begin n_fail++; $display("FAIL flush_err_cnt: got %0d/%0d expected %0d/%0d", a_err_cnt, b_err_cnt, cnt_a, cnt_b); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
      n_checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost%0d: got %b%b expected 00", i, a_out_valid, b_out_valid); end
    end
  endtask

  task automatic test_async_reset();
    bit acc;
    drive(1'b1, 32'hFFFFFFFF, 3'd7, 32'hE0, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h00300093, 3'd0, 32'hE1, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({a_out_valid, b_out_valid, a_in_ready, b_in_ready} !== 4'b0011) begin n_fail++; $display("FAIL arst_state: got %b expected 0011", {a_out_valid, b_out_valid, a_in_ready, b_in_ready}); end
    n_checks++; if (a_err_cnt !== 2'd0 || b_err_cnt !== 8'd0 || a_out_tag !== 32'h0) begin n_fail++; $display("FAIL arst_regs: got %0d/%0d tag %h expected 0", a_err_cnt, b_err_cnt, a_out_tag); end
    @(negedge clk);
    rst = 1'b0;
    q.delete(); cnt_a = 0; cnt_b = 0;
  endtask

  task automatic test_random();
    bit acc;
    for (int c = 0; c < 400; c++) begin
      n_checks++; if ({a_in_ready, b_in_ready} !== {2{q.size() < 2}}) begin n_fail++; $display("FAIL rnd%0d_in_ready: got %b expected %b", c, {a_in_ready, b_in_ready}, {2{q.size() < 2}}); end
      drive($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, acc);
      n_checks++; if ({a_out_valid, b_out_valid} !== {2{q.size() > 0}}) begin n_fail++; $display("FAIL rnd%0d_valid: got %b expected %b", c, {a_out_valid, b_out_valid}, {2{q.size() > 0}}); end
      n_checks++; if (a_err_cnt !== 2'(cnt_a) || b_err_cnt !== 8'(cnt_b)) begin n_fail++; $display("FAIL rnd%0d_err_cnt: got %0d/%0d expected %0d/%0d", c, a_err_cnt, b_err_cnt, cnt_a, cnt_b); end
      if (q.size() > 0) begin
        n_checks++;
        if (a_out_imm !== q[0].imm32 || b_out_imm !== q[0].imm64 || a_out_tag !== q[0].tag ||
            b_out_tag !== q[0].tag[15:0] || a_out_illegal !== q[0].ill || b_out_illegal !== q[0].ill) begin
          n_fail++;
          $display("FAIL rnd%0d_data: got %h/%h tag %h ill %b%b expected %h/%h tag %h ill %b",
                   c, a_out_imm, b_out_imm, a_out_tag, a_out_illegal, b_out_illegal,
                   q[0].imm32, q[0].imm64, q[0].tag, q[0].ill);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_illegal_sat();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
